// File: rtl/btn_ctrl_cond.sv
// btn_ctrl_cond: conditions the three raw Zybo push buttons into CPU debug
// run-control: run pulse, halt pulse and a 4-phase single-step request with
// timeout abort. Each button passes through a 2-flop synchroniser and a
// stable-count debouncer; only press (rising) edges create events.
// Optional feature macro: BTN_STEP_REPEAT_EN enables step auto-repeat while
// the step button is held and the CPU is halted.
module btn_ctrl_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int STEP_TIMEOUT    = 4096,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:1] zybo_buttons,
    input  logic       cpu_running,
    input  logic       step_ack,
    output logic       dbg_run_core,
    output logic       dbg_halt_core,
    output logic       step_cycle,
    output logic       step_timeout,
    output logic [3:1] btn_state
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               TO_W    = $clog2(STEP_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(STEP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } step_state_t;

    logic [3:1]       r_sync1;
    logic [3:1]       r_sync2;
    logic [3:1]       r_stable;
    logic [3:1]       r_stable_d;
    logic [CNT_W-1:0] r_db_cnt [3:1];

    logic             r_run_pulse;
    logic             r_halt_pulse;
    logic             r_step_cycle;
    logic             r_step_timeout;
    logic             r_pending;
    logic [TO_W-1:0]  r_to_cnt;
    step_state_t      r_state;

    logic [3:1]       w_evt;
    logic             w_run_evt;
    logic             w_halt_evt;
    logic             w_rep_evt;
    logic             w_step_evt;
    step_state_t      w_state_nxt;
    logic             w_step_cycle_nxt;
    logic             w_timeout_nxt;
    logic             w_pending_nxt;
    logic [TO_W-1:0]  w_to_cnt_nxt;

    // Two-flop synchroniser for the asynchronous button pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= zybo_buttons;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 3'b000;
            for (int i = 1; i <= 3; i++) begin
                r_db_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 1; i <= 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= {CNT_W{1'b0}};
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= {CNT_W{1'b0}};
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Delayed copy of the debounced levels for press-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_d <= 3'b000;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    // Press events only; halt has priority over a coincident run event
    assign w_evt      = r_stable & ~r_stable_d;
    assign w_halt_evt = w_evt[2] & cpu_running;
    assign w_run_evt  = w_evt[1] & ~cpu_running & ~w_evt[2];

`ifdef BTN_STEP_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_hold_phase;
    logic              r_rep_evt;

    // Hold counter: first synthetic step after REPEAT_DELAY, then every REPEAT_PERIOD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt   <= {HOLD_W{1'b0}};
            r_hold_phase <= 1'b0;
            r_rep_evt    <= 1'b0;
        end else if (!r_stable[3] || cpu_running) begin
            r_hold_cnt   <= {HOLD_W{1'b0}};
            r_hold_phase <= 1'b0;
            r_rep_evt    <= 1'b0;
        end else if (!r_hold_phase && (r_hold_cnt == HOLD_W'(REPEAT_DELAY - 1))) begin
            r_hold_cnt   <= {HOLD_W{1'b0}};
            r_hold_phase <= 1'b1;
            r_rep_evt    <= 1'b1;
        end else if (r_hold_phase && (r_hold_cnt == HOLD_W'(REPEAT_PERIOD - 1))) begin
            r_hold_cnt   <= {HOLD_W{1'b0}};
            r_hold_phase <= 1'b1;
            r_rep_evt    <= 1'b1;
        end else begin
            r_hold_cnt   <= r_hold_cnt + HOLD_W'(1);
            r_hold_phase <= r_hold_phase;
            r_rep_evt    <= 1'b0;
        end
    end

    assign w_rep_evt = r_rep_evt;
`else
    // Repeat timing is meaningless without the hold counter; keep the names referenced
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    assign w_rep_evt = 1'b0;
`endif

    // Step requests are only honoured while the CPU is halted
    assign w_step_evt = (w_evt[3] | w_rep_evt) & ~cpu_running;

    // Run/halt pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_pulse  <= 1'b0;
            r_halt_pulse <= 1'b0;
        end else begin
            r_run_pulse  <= w_run_evt;
            r_halt_pulse <= w_halt_evt;
        end
    end

    // Step FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Step FSM next-state: ack beats a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_step_evt || r_pending) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (step_ack) begin
                    w_state_nxt = ST_DROP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DROP: begin
                if (!step_ack) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Step FSM outputs: request level, timeout pulse, pending flag and timeout counter
    always_comb begin
        w_step_cycle_nxt = (w_state_nxt == ST_REQ);
        w_timeout_nxt    = 1'b0;
        w_pending_nxt    = r_pending;
        if (r_state == ST_REQ) begin
            if (r_to_cnt != TO_LAST) begin
                w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            end else begin
                w_to_cnt_nxt = r_to_cnt;
            end
        end else begin
            w_to_cnt_nxt = {TO_W{1'b0}};
        end
        case (r_state)
            ST_IDLE: begin
                if (w_step_evt || r_pending) begin
                    w_pending_nxt = 1'b0;
                end else begin
                    w_pending_nxt = r_pending;
                end
            end
            ST_REQ: begin
                if (!step_ack && (r_to_cnt == TO_LAST)) begin
                    w_timeout_nxt = 1'b1;
                    w_pending_nxt = 1'b0;
                end else if (w_step_evt) begin
                    w_pending_nxt = 1'b1;
                end else begin
                    w_pending_nxt = r_pending;
                end
            end
            ST_DROP: begin
                if (w_step_evt) begin
                    w_pending_nxt = 1'b1;
                end else begin
                    w_pending_nxt = r_pending;
                end
            end
            default: begin
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    // Step output registers; async reset drops step_cycle at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cycle   <= 1'b0;
            r_step_timeout <= 1'b0;
            r_pending      <= 1'b0;
            r_to_cnt       <= {TO_W{1'b0}};
        end else begin
            r_step_cycle   <= w_step_cycle_nxt;
            r_step_timeout <= w_timeout_nxt;
            r_pending      <= w_pending_nxt;
            r_to_cnt       <= w_to_cnt_nxt;
        end
    end

    assign dbg_run_core  = r_run_pulse;
    assign dbg_halt_core = r_halt_pulse;
    assign step_cycle    = r_step_cycle;
    assign step_timeout  = r_step_timeout;
    assign btn_state     = r_stable;

endmodule

// File: tb/tb_btn_ctrl_cond.sv
// Scoreboard bench for btn_ctrl_cond: stimulus pushes expected output events
// (kind + cycle) into a queue, a monitor pops and compares on every output event.
module tb_btn_ctrl_cond;

    localparam int K_RUN  = 0;
    localparam int K_HALT = 1;
    localparam int K_RISE = 2;
    localparam int K_FALL = 3;
    localparam int K_TMO  = 4;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:1] btn;
    logic       cpu_running;
    logic       step_ack;
    logic       dbg_run_core;
    logic       dbg_halt_core;
    logic       step_cycle;
    logic       step_timeout;
    logic [3:1] btn_state;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    btn_ctrl_cond #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (2),
        .STEP_TIMEOUT   (16),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .zybo_buttons (btn),
        .cpu_running  (cpu_running),
        .step_ack     (step_ack),
        .dbg_run_core (dbg_run_core),
        .dbg_halt_core(dbg_halt_core),
        .step_cycle   (step_cycle),
        .step_timeout (step_timeout),
        .btn_state    (btn_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_RUN:   return "run";
            K_HALT:  return "halt";
            K_RISE:  return "step_rise";
            K_FALL:  return "step_fall";
            K_TMO:   return "timeout";
            default: return "none";
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic see_evt(input int kind);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got %s@%0d, expected none", kname(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                n_errors++;
                $display("FAIL event_order: got %s@%0d, expected %s@%0d",
                         kname(kind), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    task automatic monitor_loop();
        logic prev_sc;
        prev_sc = 1'b0;
        forever begin
            @(negedge clk);
            if (dbg_run_core)             see_evt(K_RUN);
            if (dbg_halt_core)            see_evt(K_HALT);
            if (step_cycle && !prev_sc)   see_evt(K_RISE);
            if (!step_cycle && prev_sc)   see_evt(K_FALL);
            if (step_timeout)             see_evt(K_TMO);
            prev_sc = step_cycle;
        end
    endtask

    // One step press acked three cycles after the request rises
    task automatic step_press_ack();
        int c;
        c = cyc;
        btn[3] = 1'b1;
        expect_evt(K_RISE, c + 7);
        expect_evt(K_FALL, c + 11);
        tick(4);
        btn[3] = 1'b0;
        tick(6);
        step_ack = 1'b1;
        tick(3);
        step_ack = 1'b0;
        tick(12);
    endtask

    initial begin
        int c;
        rst_n       = 1'b0;
        btn         = 3'b000;
        cpu_running = 1'b0;
        step_ack    = 1'b0;
        fork
            monitor_loop();
        join_none

        // Reset state, raw buttons ignored while in reset
        tick(3);
        check_val("rst_run", {31'd0, dbg_run_core}, 32'd0);
        check_val("rst_halt", {31'd0, dbg_halt_core}, 32'd0);
        check_val("rst_step", {31'd0, step_cycle}, 32'd0);
        check_val("rst_tmo", {31'd0, step_timeout}, 32'd0);
        btn = 3'b111;
        tick(8);
        check_val("rst_btn_state", {29'd0, btn_state}, 32'd0);
        btn = 3'b000;
        tick(2);
        rst_n = 1'b1;
        tick(4);

        // Run press while halted: one pulse 7 edges after first sample
        c = cyc;
        btn[1] = 1'b1;
        expect_evt(K_RUN, c + 7);
        tick(20);
        check_val("btn_state_run", {29'd0, btn_state}, 32'd1);
        btn[1] = 1'b0;
        tick(12);
        check_val("btn_state_release", {29'd0, btn_state}, 32'd0);

        // Halt while not running is discarded
        btn[2] = 1'b1;
        tick(8);
        btn[2] = 1'b0;
        tick(12);

        // CPU running: glitch rejected, real halt press pulses once
        cpu_running = 1'b1;
        tick(2);
        btn[2] = 1'b1;
        tick(3);
        btn[2] = 1'b0;
        tick(2);
        check_val("glitch_state", {29'd0, btn_state}, 32'd0);
        tick(10);
        c = cyc;
        btn[2] = 1'b1;
        expect_evt(K_HALT, c + 7);
        tick(10);
        check_val("btn_state_halt", {29'd0, btn_state}, 32'd2);
        btn[2] = 1'b0;
        tick(12);

        // Run and step while running are discarded
        btn[1] = 1'b1;
        tick(8);
        btn[1] = 1'b0;
        tick(12);
        btn[3] = 1'b1;
        tick(8);
        check_val("btn_state_step", {29'd0, btn_state}, 32'd4);
        btn[3] = 1'b0;
        tick(12);
        cpu_running = 1'b0;
        tick(2);

        // Ack in IDLE is ignored
        step_ack = 1'b1;
        tick(4);
        step_ack = 1'b0;
        tick(2);

        // Two complete handshakes
        step_press_ack();
        step_press_ack();

        // Two presses during a request: one extra request, third press lost
        c = cyc;
        expect_evt(K_RISE, c + 7);
        expect_evt(K_FALL, c + 21);
        expect_evt(K_RISE, c + 36);
        expect_evt(K_FALL, c + 40);
        btn[3] = 1'b1;
        tick(4);
        btn[3] = 1'b0;
        tick(8);
        btn[3] = 1'b1;
        tick(4);
        btn[3] = 1'b0;
        tick(4);
        step_ack = 1'b1;
        tick(4);
        btn[3] = 1'b1;
        tick(4);
        btn[3] = 1'b0;
        tick(6);
        step_ack = 1'b0;
        tick(5);
        step_ack = 1'b1;
        tick(3);
        step_ack = 1'b0;
        tick(20);

        // No ack: abort 16 cycles after request entry
        c = cyc;
        expect_evt(K_RISE, c + 7);
        expect_evt(K_FALL, c + 23);
        expect_evt(K_TMO, c + 23);
        btn[3] = 1'b1;
        tick(4);
        btn[3] = 1'b0;
        tick(26);

        // Asynchronous reset mid-request drops step_cycle without a clock edge
        c = cyc;
        expect_evt(K_RISE, c + 7);
        expect_evt(K_FALL, c + 11);
        btn[3] = 1'b1;
        tick(4);
        btn[3] = 1'b0;
        tick(6);
        check_val("step_before_reset", {31'd0, step_cycle}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("step_async_drop", {31'd0, step_cycle}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(12);

        // Long hold with prompt acks
        c = cyc;
`ifdef BTN_STEP_REPEAT_EN
        expect_evt(K_RISE, c + 7);
        expect_evt(K_FALL, c + 8);
        for (int k = 0; k < 4; k++) begin
            expect_evt(K_RISE, c + 27 + 8 * k);
            expect_evt(K_FALL, c + 28 + 8 * k);
        end
`else
        expect_evt(K_RISE, c + 7);
        expect_evt(K_FALL, c + 8);
`endif
        for (int k = 0; k < 70; k++) begin
            if (k == 0)  btn[3] = 1'b1;
            if (k == 50) btn[3] = 1'b0;
            step_ack = step_cycle;
            tick(1);
        end
        step_ack = 1'b0;
        tick(15);

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_ctrl_cond.md
Name: btn_ctrl_cond

Overview:
- Conditions the three raw Zybo push buttons into the CPU debug run-control inputs: run pulse, halt pulse, and a 4-phase single-step request.
- Sits directly upstream of the cpu top, between the board pins and `dbg_run_core`, `dbg_halt_core` and `step_cycle`/`step_ack`.
- Replaces the bare edge-detect registers with synchronisation, debounce, step handshake sequencing and timeout detection.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a debounced level changes (≥2).
- CNT_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- STEP_TIMEOUT, 4096: cycles in REQ without `step_ack` before the request is aborted.
- REPEAT_DELAY, 50000000: hold time before step auto-repeat starts (optional feature only).
- REPEAT_PERIOD, 10000000: auto-repeat interval (optional feature only).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- zybo_buttons  input  3 ([3:1])  raw buttons: [1]=run, [2]=halt, [3]=step; asynchronous
- cpu_running  input  1  1 => CPU running
- step_ack  input  1  CPU step acknowledge, 4-phase
- dbg_run_core  output  1  1-cycle run pulse
- dbg_halt_core  output  1  1-cycle halt pulse
- step_cycle  output  1  step request level, 4-phase
- step_timeout  output  1  1-cycle pulse on aborted step
- btn_state  output  3 ([3:1])  debounced button levels

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0. Synchronisers, debounced levels and counters 0. Step FSM in IDLE, pending bit 0. Reset mid-handshake drops `step_cycle` immediately (asynchronously).
- Sync: 2-flop synchroniser per button.
- Debounce, per button:
  - If sync != stable, the counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync and the counter clears.
  - Any cycle with sync == stable clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - `btn_state` = stable levels.
- Latency: raw high first sampled at edge 1 → stable rises at edge DEBOUNCE_CYCLES+2 → event pulse registered at edge DEBOUNCE_CYCLES+3.
- Events: rising edge of a stable level (stable & ~stable_d). Releases produce no events.
- `dbg_run_core`: run event while `cpu_running`=0; otherwise discarded.
- `dbg_halt_core`: halt event while `cpu_running`=1; otherwise discarded.
- Run and halt events in the same cycle: halt wins, run is dropped.
- Step events while `cpu_running`=1 are discarded.
- Step FSM:
  - IDLE: on a step event or pending=1 → REQ; `step_cycle` <= 1; pending clears.
  - REQ: on `step_ack`=1 → DROP; `step_cycle` <= 0. If the timeout counter reaches STEP_TIMEOUT-1 first → IDLE, `step_cycle` <= 0, `step_timeout` pulses, pending clears.
  - DROP: on `step_ack`=0 → IDLE.
  - A step event in REQ or DROP sets pending (saturating at 1; further events are lost).
  - `step_ack` high while in IDLE is ignored.
  - A step event on the same edge as the REQ→DROP transition sets pending.
- Timeout counter: cleared on REQ entry; saturates; width $clog2(STEP_TIMEOUT).
- Minimum step spacing: REQ→DROP→IDLE→REQ, i.e. ≥1 IDLE cycle between requests.

Optional Feature:
- Macro: BTN_STEP_REPEAT_EN.
- Defined:
  - While stable step = 1 and `cpu_running` = 0, a hold counter runs.
  - After REPEAT_DELAY cycles it generates a synthetic step event, then one every REPEAT_PERIOD cycles.
  - The counter clears on release or when `cpu_running` = 1.
  - Synthetic events use the same pending/FSM path as real events.
- Undefined: no hold counter is implemented; one event per press.
- REPEAT_DELAY and REPEAT_PERIOD remain declared but are unused.

Test Plan (DEBOUNCE_CYCLES=4, STEP_TIMEOUT=16, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset release, `cpu_running`=0, raw run button held high from edge 1 → `dbg_run_core` high for exactly the cycle after edge 7 and never again while held; `btn_state` = 3'b001.
- 3-cycle raw glitch on halt with `cpu_running`=1 → no `dbg_halt_core`, `btn_state` unchanged. A 10-cycle press → exactly one halt pulse.
- Step press, `cpu_running`=0: `step_cycle` rises after edge 7. Drive `step_ack`=1 three cycles later → `step_cycle` falls the next edge. `step_ack`=0 → IDLE. Second press → second request.
- Step pressed twice during REQ → exactly one extra request after the first handshake completes; third press lost.
- No `step_ack` after a request → `step_cycle` falls and `step_timeout` pulses once, 16 cycles after REQ entry. Assert `rst_n`=0 mid-REQ → `step_cycle` drops immediately.
- With BTN_STEP_REPEAT_EN: hold step 60 cycles, ack every request within 2 cycles → 1 + auto events at hold+20, +28, +36 … each producing a request. Without the macro → exactly 1 request.
